// File: rtl/cache_refill_arbiter.sv
// ---------------------------------------------------------------------------
// cache_refill_arbiter
//
// Arbitrates cache-line refills from N_REQ miss requesters onto a single
// memory port. A requester is picked round-robin. It is acknowledged with a
// one-cycle req_ready pulse. Its line is then fetched from memory as BEATS
// consecutive beats. Each beat is forwarded to the owner one cycle after
// memory completes it.
//
// Parameters
//   N_REQ   number of requesters (2..8)
//   ADDR_W  address width
//   DATA_W  memory beat width (BYTES = DATA_W/8)
//   BEATS   beats per cache line (power of two, 2..16)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   req_valid  per-requester miss request, held until accepted
//   req_addr   miss address of requester i in [i*ADDR_W +: ADDR_W]
//   req_ready  one-hot, one-cycle acceptance pulse
//   rsp_valid  one-hot beat valid towards the owning requester
//   rsp_data   shared refill data bus
//   rsp_last   final beat of the line
//   mem_req    memory beat request
//   mem_addr   current beat address
//   mem_ready  memory beat complete, mem_rdata valid
//   mem_rdata  memory read data
// ---------------------------------------------------------------------------
module cache_refill_arbiter #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_last,
   output logic                      mem_req,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic                      mem_ready,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int BYTES  = DATA_W / 8;
   localparam int BYTE_W = $clog2(BYTES);
   localparam int CNT_W  = $clog2(BEATS);
   localparam int OFF_W  = $clog2(BYTES * BEATS);
   localparam int LINE_W = ADDR_W - OFF_W;
   localparam int PTR_W  = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BURST = 2'd2
   } state_t;

   state_t                  state_r;
   logic [PTR_W-1:0]        rr_ptr_r;
   logic [PTR_W-1:0]        owner_r;
   logic [LINE_W-1:0]       line_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [N_REQ-1:0]        req_ready_r;
   logic [N_REQ-1:0]        rsp_valid_r;
   logic [DATA_W-1:0]       rsp_data_r;
   logic                    rsp_last_r;
   logic                    mem_req_r;
   logic [ADDR_W-1:0]       mem_addr_r;

   logic [PTR_W-1:0]        sel_s;
   logic [ADDR_W-1:0]       sel_addr_s;

   // First requester with valid set, searching upward from ptr and wrapping.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [PTR_W-1:0] ptr);
      logic found;
      int   idx;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (!found && valid[idx]) begin
            rr_pick = PTR_W'(idx);
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // The beat index is placed directly above the byte offset, so the address
   // can never carry out of the line's alignment boundary.
   function automatic logic [ADDR_W-1:0] beat_addr(input logic [LINE_W-1:0] line,
                                                   input logic [CNT_W-1:0]  beat);
      beat_addr = {line, {OFF_W{1'b0}}} | (ADDR_W'(beat) << BYTE_W);
   endfunction

   // Round-robin candidate and its address, used only while IDLE.
   always_comb begin
      sel_s      = rr_pick(req_valid, rr_ptr_r);
      sel_addr_s = req_addr[int'(sel_s)*ADDR_W +: ADDR_W];
   end

   // Arbitration / refill FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         rr_ptr_r    <= '0;
         owner_r     <= '0;
         line_r      <= '0;
         cnt_r       <= '0;
         req_ready_r <= '0;
         rsp_valid_r <= '0;
         rsp_data_r  <= '0;
         rsp_last_r  <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_addr_r  <= '0;
      end else begin
         // Pulse-type outputs default low every cycle.
         req_ready_r <= '0;
         rsp_valid_r <= '0;
         rsp_data_r  <= '0;
         rsp_last_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               mem_req_r  <= 1'b0;
               mem_addr_r <= '0;
               if (|req_valid) begin
                  // Owner and line address are captured here and stay frozen
                  // until the line completes. The requester still holds its
                  // request during GRANT, so the value is the same either way.
                  owner_r     <= sel_s;
                  line_r      <= LINE_W'(sel_addr_s >> OFF_W);
                  req_ready_r <= onehot(sel_s);
                  state_r     <= GRANT;
               end else begin
                  state_r     <= IDLE;
               end
            end
            GRANT: begin
               cnt_r      <= '0;
               mem_req_r  <= 1'b1;
               mem_addr_r <= beat_addr(line_r, '0);
               state_r    <= BURST;
            end
            BURST: begin
               if (mem_ready) begin
                  rsp_valid_r <= onehot(owner_r);
                  rsp_data_r  <= mem_rdata;
                  rsp_last_r  <= (cnt_r == CNT_W'(BEATS - 1));
                  if (cnt_r == CNT_W'(BEATS - 1)) begin
                     cnt_r      <= '0;
                     mem_req_r  <= 1'b0;
                     mem_addr_r <= '0;
                     rr_ptr_r   <= (owner_r == PTR_W'(N_REQ - 1)) ? '0 : owner_r + PTR_W'(1);
                     state_r    <= IDLE;
                  end else begin
                     cnt_r      <= cnt_r + CNT_W'(1);
                     mem_addr_r <= beat_addr(line_r, cnt_r + CNT_W'(1));
                     state_r    <= BURST;
                  end
               end else begin
                  // Wait state: address, count and request hold indefinitely.
                  state_r <= BURST;
               end
            end
            default: begin
               mem_req_r  <= 1'b0;
               mem_addr_r <= '0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_last  = rsp_last_r;
   assign mem_req   = mem_req_r;
   assign mem_addr  = mem_addr_r;

endmodule

// File: doc/cache_refill_arbiter.md
CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, SHALL set the number of cache miss requesters (2..8).
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the memory beat width; BYTES = DATA_W/8.
REQ-004 Parameter BEATS, default 4, SHALL set the beats per cache line (power of two, 2..16).
REQ-005 clk  in  1  SHALL be the clock; all state changes on its rising edge.
REQ-006 rst  in  1  SHALL be the reset, asynchronous, active-low.
REQ-007 req_valid  in  N_REQ  SHALL carry per-requester miss requests, held high until accepted.
REQ-008 req_addr  in  N_REQ*ADDR_W  SHALL carry the miss address of requester i in slice [i*ADDR_W +: ADDR_W].
REQ-009 req_ready  out  N_REQ  SHALL be a one-hot, one-cycle acceptance pulse.
REQ-010 rsp_valid  out  N_REQ  SHALL be a one-hot beat-valid to the owning requester.
REQ-011 rsp_data  out  DATA_W  SHALL be the shared refill data bus.
REQ-012 rsp_last  out  1  SHALL mark the final beat of a line.
REQ-013 mem_req  out  1  SHALL request a memory beat.
REQ-014 mem_addr  out  ADDR_W  SHALL be the current beat address.
REQ-015 mem_ready  in  1  SHALL indicate mem_rdata is valid and the beat is complete.
REQ-016 mem_rdata  in  DATA_W  SHALL be the memory read data.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT and BURST.
REQ-018 In IDLE with any req_valid set, the arbiter SHALL select one requester round-robin, starting the search at pointer rr_ptr and wrapping at N_REQ-1 to 0, and SHALL go to GRANT.
REQ-019 In IDLE with no req_valid set, the FSM SHALL remain in IDLE, all outputs at 0.
REQ-020 In GRANT, req_ready[owner] SHALL be 1 for exactly that cycle, the line base (req_addr aligned down to BYTES*BEATS) SHALL be latched, beat counter cnt SHALL clear to 0, and the FSM SHALL go to BURST.
REQ-021 In BURST, mem_req SHALL be 1 and mem_addr SHALL equal base + cnt*BYTES.
REQ-022 On each BURST cycle with mem_ready=1, cnt SHALL increment; the following cycle rsp_valid[owner]=1 and rsp_data holds the registered mem_rdata (1-cycle latency).
REQ-023 rsp_last SHALL be 1 coincident with the rsp_valid of beat BEATS-1 only.
REQ-024 On mem_ready with cnt==BEATS-1, the FSM SHALL return to IDLE, mem_req SHALL drop the next cycle, and rr_ptr SHALL become (owner+1) mod N_REQ.
REQ-025 mem_ready while not in BURST SHALL be ignored.
REQ-026 BURST with mem_ready=0 SHALL hold cnt, mem_addr and mem_req unchanged, with no timeout.
REQ-027 Requests arriving or dropping during GRANT/BURST SHALL NOT affect the current owner or latched address.
REQ-028 The final rsp_valid of line n MAY coincide with the IDLE cycle that selects line n+1; a new line's first mem_req SHALL follow no sooner than 2 cycles after the previous last mem_ready.
REQ-029 Address arithmetic SHALL be ADDR_W-bit modulo; the line never crosses its alignment boundary.

Reset
REQ-030 While rst=0, state SHALL be IDLE, rr_ptr=0, cnt=0, and req_ready, rsp_valid, rsp_data, rsp_last, mem_req, mem_addr SHALL all be 0.
REQ-031 Reset asserted mid-BURST SHALL abort the line immediately with no further rsp_valid; after release, arbitration restarts from requester 0.

Verification
REQ-032 Single request: req_valid=01, req_addr[0]=0x1008, mem_ready always 1 -> req_ready=01 pulse; mem_addr 0x1000,0x1004,0x1008,0x100C; four rsp_valid[0] beats, rsp_last on the 4th.
REQ-033 Contention: req_valid=11 held -> owner order 0,1,0,1 across four lines, with each req_ready pulse one-hot.
REQ-034 Wait states: mem_ready toggling 1,0,0,1,... -> mem_addr held during stalls; exactly 4 beats, data order preserved.
REQ-035 Reset mid-burst: rst=0 after beat 2 -> all outputs 0 next edge; after release with req_valid=10, requester 1 is granted first from rr_ptr=0 search.
REQ-036 Stray mem_ready=1 in IDLE -> no rsp_valid, no state change.
REQ-037 Wrap address: req_addr=0xFFFFFFF4 -> beats at 0xFFFFFFF0..0xFFFFFFFC, no overflow into 0x0.
